operand_fetch: RTL

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/operand_fetch_pkg.sv | 20 ++
 rtl/operand_scoreboard.sv | 36 +++
 rtl/operand_fetch.sv | 121 ++++++++++++
 3 files changed

// File: rtl/operand_fetch_pkg.sv
// Shared constants for the operand fetch and writeback stages.
// Holds default data/register/opcode widths, the register count and opcode values.
// No logic; imported by operand_fetch and operand_scoreboard.
package operand_fetch_pkg;

  localparam int DEF_WIDTH = 4;  // data width
  localparam int DEF_NREG  = 3;  // register address width
  localparam int DEF_NOPER = 3;  // opcode width
  localparam int NUM_REGS  = 1 << DEF_NREG;

  // Opcode values are carried through untouched; listed here so the
  // writeback/execute stages agree on the encoding.
  typedef enum logic [DEF_NOPER-1:0] {
    OP_AND = 3'd0,
    OP_OR  = 3'd1,
    OP_ADD = 3'd2,
    OP_SUB = 3'd3
  } opcode_e;

endpackage

// File: rtl/operand_scoreboard.sv
// Per-register busy bits tracking destinations of in-flight instructions.
// Ports: set_en_i/set_addr_i mark a destination busy, clr_en_i/clr_addr_i
// retire it on writeback, busy_o exposes the raw bits. Set beats clear.
import operand_fetch_pkg::*;

module operand_scoreboard #(
  parameter int NREG = DEF_NREG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en_i,
  input  logic [NREG-1:0]   set_addr_i,
  input  logic              clr_en_i,
  input  logic [NREG-1:0]   clr_addr_i,
  output logic [2**NREG-1:0] busy_o
);

  logic [2**NREG-1:0] busy_q;
  logic [2**NREG-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) busy_d[clr_addr_i] = 1'b0;
    // Applied after the clear so a same-cycle issue to the register being
    // written back leaves it busy for the new producer.
    if (set_en_i) busy_d[set_addr_i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads sources, bypasses writeback data, stalls on
// scoreboard hazards and registers one instruction for the downstream stage.
// Ports: upstream valid/ready instruction, RF read ports, writeback snoop,
// downstream valid/ready result; pending exposes the busy bits.
import operand_fetch_pkg::*;

module operand_fetch #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREG  = DEF_NREG,
  parameter int NOPER = DEF_NOPER
) (
  input  logic               clk,
  input  logic               rst,
  // upstream
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NOPER-1:0]   oper,
  input  logic [NREG-1:0]    reg_addr1,
  input  logic [NREG-1:0]    reg_addr2,
  input  logic [NREG-1:0]    reg_addr3,
  input  logic               sel,
  input  logic [WIDTH-1:0]   imm,
  // register file read
  output logic [NREG-1:0]    rf_addr1,
  output logic [NREG-1:0]    rf_addr2,
  input  logic [WIDTH-1:0]   rf_data1,
  input  logic [WIDTH-1:0]   rf_data2,
  // writeback snoop
  input  logic               wb_en,
  input  logic [NREG-1:0]    wb_addr,
  input  logic [WIDTH-1:0]   wb_data,
  // downstream
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NOPER-1:0]   out_oper,
  output logic [WIDTH-1:0]   out_a,
  output logic [WIDTH-1:0]   out_b,
  output logic [NREG-1:0]    out_dst,
  output logic [2**NREG-1:0] pending
);

  logic [2**NREG-1:0] busy;

  logic               out_valid_q, out_valid_d;
  logic [NOPER-1:0]   out_oper_q,  out_oper_d;
  logic [WIDTH-1:0]   out_a_q,     out_a_d;
  logic [WIDTH-1:0]   out_b_q,     out_b_d;
  logic [NREG-1:0]    out_dst_q,   out_dst_d;

  logic hit_a, hit_b, hit_d;
  logic src_a_rdy, src_b_rdy, dst_rdy;
  logic hazard, accept;

  assign rf_addr1 = reg_addr1;
  assign rf_addr2 = reg_addr2;

  // A writeback landing this cycle both satisfies the dependency and
  // supplies the value the register file has not yet stored.
  assign hit_a = wb_en && (wb_addr == reg_addr1);
  assign hit_b = wb_en && (wb_addr == reg_addr2);
  assign hit_d = wb_en && (wb_addr == reg_addr3);

  assign src_a_rdy = !busy[reg_addr1] || hit_a;
  assign src_b_rdy = sel || !busy[reg_addr2] || hit_b;
  assign dst_rdy   = !busy[reg_addr3] || hit_d;

  assign hazard   = !(src_a_rdy && src_b_rdy && dst_rdy);
  assign in_ready = (!out_valid_q || out_ready) && !hazard && !rst;
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_oper_d  = out_oper_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_dst_d   = out_dst_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_oper_d  = oper;
      out_a_d     = hit_a ? wb_data : rf_data1;
      out_b_d     = sel ? imm : (hit_b ? wb_data : rf_data2);
      out_dst_d   = reg_addr3;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_oper_q  <= '0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_dst_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_oper_q  <= out_oper_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_dst_q   <= out_dst_d;
    end
  end

  operand_scoreboard #(.NREG(NREG)) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .set_en_i   (accept),
    .set_addr_i (reg_addr3),
    .clr_en_i   (wb_en),
    .clr_addr_i (wb_addr),
    .busy_o     (busy)
  );

  assign out_valid = out_valid_q;
  assign out_oper  = out_oper_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_dst   = out_dst_q;
  assign pending   = busy;

endmodule
